// File: rtl/pagerank_pkg.sv
// Shared PageRank types and fixed-point constants for the scheduler and the update datapath.
// Combinational definitions only; no latency, no backpressure.
package pagerank_pkg;

  localparam int PR_N      = 16;
  localparam int PR_WIDTH  = 16;
  localparam int PR_ITER_W = 8;

  // Q0.WIDTH fixed point: base is 1.0, d is the damping factor (~0.15), db = 1-d.
  localparam int PR_BASE = 1 << PR_WIDTH;
  localparam int PR_D    = 'h2666;
  localparam int PR_DB   = PR_BASE - PR_D;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    REQ,
    WR,
    CHECK,
    FIN
  } state_t;

  function automatic int init_val(input int n, input int width);
    return (1 << width) / n;
  endfunction

  localparam int PR_INIT_VAL = init_val(PR_N, PR_WIDTH);

endpackage

// File: rtl/pagerank_scheduler_if.sv
// Scheduler <-> datapath/node-store link: update request/ack and node-value write port.
// Request is held until ack; the write port has no backpressure.
interface pagerank_scheduler_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16
);
  localparam int PW = $clog2(N);

  logic             upd_req;
  logic [PW-1:0]    upd_page;
  logic             upd_ack;
  logic [WIDTH-1:0] upd_old;
  logic [WIDTH-1:0] upd_new;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output upd_req, upd_page, wr_en, wr_addr, wr_data,
    input  upd_ack, upd_old, upd_new
  );

  modport slave (
    input  upd_req, upd_page, wr_en, wr_addr, wr_data,
    output upd_ack, upd_old, upd_new
  );

endinterface

// File: rtl/pagerank_delta_max.sv
// |new-old| with a registered running maximum; clr wins over en, result valid the cycle after en.
// No backpressure: en is a single-cycle capture strobe.
module pagerank_delta_max #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] new_val,
  input  logic [WIDTH-1:0] old_val,
  output logic [WIDTH-1:0] max_delta
);

  logic [WIDTH-1:0] delta;

  assign delta = (new_val >= old_val) ? (new_val - old_val) : (old_val - new_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_delta <= '0;
    end else if (clr) begin
      max_delta <= '0;
    end else if (en && (delta > max_delta)) begin
      max_delta <= delta;
    end
  end

endmodule

// File: rtl/pagerank_scheduler.sv
// PageRank sweep sequencer: N-cycle init, then 2 cycles/page + datapath wait, 1-cycle convergence check.
// Holds upd_req/upd_page until upd_ack; abort returns to IDLE on the next cycle without a done pulse.
module pagerank_scheduler
  import pagerank_pkg::*;
#(
  parameter int N      = PR_N,
  parameter int WIDTH  = PR_WIDTH,
  parameter int ITER_W = PR_ITER_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      eps,
  input  logic [ITER_W-1:0]     max_iter,
  pagerank_scheduler_if.master  dp,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic [ITER_W-1:0]     iter_count
);

  localparam int              PW        = $clog2(N);
  localparam logic [PW-1:0]   LAST_PAGE = PW'(N - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(init_val(N, WIDTH));

  state_t            state;
  logic [PW-1:0]     page;
  logic [WIDTH-1:0]  eps_q;
  logic [ITER_W-1:0] max_iter_q;
  logic [WIDTH-1:0]  max_delta;
  logic [ITER_W-1:0] iter_next;
  logic              md_clr;
  logic              md_en;

  assign iter_next = iter_count + 1'b1;
  // Clearing in CHECK is safe: the compare reads max_delta before the clearing edge.
  assign md_clr    = (state == INIT) || (state == CHECK);
  assign md_en     = (state == REQ) && dp.upd_ack && !abort;

  pagerank_delta_max #(
    .WIDTH(WIDTH)
  ) u_delta_max (
    .clk      (clk),
    .reset    (reset),
    .clr      (md_clr),
    .en       (md_en),
    .new_val  (dp.upd_new),
    .old_val  (dp.upd_old),
    .max_delta(max_delta)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      page        <= '0;
      eps_q       <= '0;
      max_iter_q  <= '0;
      dp.upd_req  <= 1'b0;
      dp.upd_page <= '0;
      dp.wr_en    <= 1'b0;
      dp.wr_addr  <= '0;
      dp.wr_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      iter_count  <= '0;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      dp.upd_req <= 1'b0;
      dp.wr_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= INIT;
            eps_q      <= eps;
            max_iter_q <= max_iter;
            iter_count <= '0;
            converged  <= 1'b0;
            page       <= '0;
            busy       <= 1'b1;
            dp.wr_en   <= 1'b1;
            dp.wr_addr <= '0;
            dp.wr_data <= INIT_VAL;
          end
        end
        INIT: begin
          if (page == LAST_PAGE) begin
            dp.wr_en <= 1'b0;
            page     <= '0;
            if (max_iter_q == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= REQ;
              dp.upd_req  <= 1'b1;
              dp.upd_page <= '0;
            end
          end else begin
            page       <= page + 1'b1;
            dp.wr_addr <= page + 1'b1;
          end
        end
        REQ: begin
          if (dp.upd_ack) begin
            state      <= WR;
            dp.upd_req <= 1'b0;
            dp.wr_en   <= 1'b1;
            dp.wr_addr <= page;
            dp.wr_data <= dp.upd_new;
          end
        end
        WR: begin
          dp.wr_en <= 1'b0;
          if (page == LAST_PAGE) begin
            state <= CHECK;
          end else begin
            state       <= REQ;
            page        <= page + 1'b1;
            dp.upd_req  <= 1'b1;
            dp.upd_page <= page + 1'b1;
          end
        end
        CHECK: begin
          iter_count <= iter_next;
          if (max_delta <= eps_q) begin
            state     <= FIN;
            converged <= 1'b1;
            done      <= 1'b1;
          end else if (iter_next == max_iter_q) begin
            state     <= FIN;
            converged <= 1'b0;
            done      <= 1'b1;
          end else begin
            state       <= REQ;
            page        <= '0;
            dp.upd_req  <= 1'b1;
            dp.upd_page <= '0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_scheduler.sv
// Directed bench: a node-store/datapath model answers update requests; per-run vectors plus abort/reset sequences.
module tb_pagerank_scheduler;
  import pagerank_pkg::*;

  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] eps;
  logic [7:0]  max_iter;
  logic        busy;
  logic        done;
  logic        converged;
  logic [7:0]  iter_count;

  pagerank_scheduler_if #(.N(16), .WIDTH(16)) dp ();

  pagerank_scheduler #(.N(16), .WIDTH(16), .ITER_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .eps       (eps),
    .max_iter  (max_iter),
    .dp        (dp),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .iter_count(iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [7:0]  max_iter;
    logic [15:0] eps;
    int          mode;
    int          delay;
    bit          always_ack;
    logic [7:0]  x_iter;
    bit          x_conv;
    int          x_busy;
    int          x_writes;
    int          x_req;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Datapath model configuration and per-run observations.
  int          mode;
  int          delay;
  bit          always_ack;
  int          wcnt;
  int          wcount;
  int          sweep;
  int          busy_cyc;
  int          done_cnt;
  int          req_cyc;
  bit          overlap;
  bit          unstable;
  bit          prev_req;
  logic [3:0]  prev_page;
  logic [15:0] mem     [N];
  logic [15:0] exp_mem [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] delta_of(input int m, input int s, input int p);
    case (m)
      0: return 16'h0010;
      1: return 16'h0000;
      default: return (s == 0) ? ((p == 7) ? 16'h0040 : 16'h0008) : 16'h0010;
    endcase
  endfunction

  task automatic clear_mon();
    wcnt = 0; wcount = 0; sweep = 0; busy_cyc = 0; done_cnt = 0; req_cyc = 0;
    overlap = 1'b0; unstable = 1'b0; prev_req = 1'b0; prev_page = '0;
    for (int i = 0; i < N; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
  endtask

  // Node store + datapath: observes at negedge, answers with upd_old/upd_new/upd_ack.
  initial begin
    int          ea;
    logic [15:0] ed;
    dp.upd_ack = 1'b0;
    dp.upd_old = '0;
    dp.upd_new = '0;
    forever begin
      @(negedge clk);
      if (dp.wr_en && dp.upd_req) overlap = 1'b1;
      if (dp.upd_req && prev_req && (dp.upd_page != prev_page)) unstable = 1'b1;
      prev_req  = dp.upd_req;
      prev_page = dp.upd_page;
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (dp.upd_req) req_cyc++;
      if (dp.wr_en) begin
        if (wcount < N) begin
          ea = wcount;
          ed = 16'h1000;
        end else begin
          ea = (wcount - N) % N;
          ed = exp_mem[ea] + delta_of(mode, sweep, ea);
        end
        check("wr_addr", 32'(dp.wr_addr), 32'(ea));
        check("wr_data", 32'(dp.wr_data), 32'(ed));
        mem[dp.wr_addr] = dp.wr_data;
        exp_mem[ea]     = ed;
        if (wcount >= N && ea == N - 1) sweep++;
        wcount++;
      end
      if (dp.upd_req) begin
        dp.upd_ack = always_ack || (wcnt >= delay);
        wcnt++;
      end else begin
        wcnt = 0;
        dp.upd_ack = always_ack;
      end
      dp.upd_old = mem[dp.upd_page];
      dp.upd_new = mem[dp.upd_page] + delta_of(mode, sweep, int'(dp.upd_page));
    end
  end

  task automatic begin_run(input int m, input int d, input bit aa, input logic [15:0] e, input logic [7:0] mi);
    mode = m; delay = d; always_ack = aa;
    clear_mon();
    eps = e; max_iter = mi;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    begin_run(v.mode, v.delay, v.always_ack, v.eps, v.max_iter);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check({v.name, ".done_pulses"}, 32'(done_cnt), 32'd1);
    check({v.name, ".iter_count"}, 32'(iter_count), 32'(v.x_iter));
    check({v.name, ".converged"}, 32'(converged), 32'(v.x_conv));
    check({v.name, ".busy_cycles"}, 32'(busy_cyc), 32'(v.x_busy));
    check({v.name, ".writes"}, 32'(wcount), 32'(v.x_writes));
    check({v.name, ".req_cycles"}, 32'(req_cyc), 32'(v.x_req));
    check({v.name, ".req_wr_overlap"}, 32'(overlap), 32'd0);
    check({v.name, ".page_unstable"}, 32'(unstable), 32'd0);
    check({v.name, ".idle_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int          wr_before;
    int          pg;
    int          c;
    reset = 1'b0; start = 1'b0; abort = 1'b0; eps = '0; max_iter = '0;
    mode = 0; delay = 0; always_ack = 1'b0;
    clear_mon();

    //                name       mi  eps      mode dly ack  iter conv busy wr  req
    vecs[0] = '{"limit3",  8'd3, 16'h0000, 0, 0, 1'b1, 8'd3, 1'b0, 116, 64, 48};
    vecs[1] = '{"nochange",8'd8, 16'h0000, 1, 0, 1'b1, 8'd1, 1'b1,  50, 32, 16};
    vecs[2] = '{"slowack", 8'd8, 16'h0020, 2, 5, 1'b0, 8'd2, 1'b1, 243, 48, 192};
    vecs[3] = '{"maxit0",  8'd0, 16'h0100, 0, 0, 1'b1, 8'd0, 1'b0,  17, 16, 0};
    vecs[4] = '{"eps_eq",  8'd4, 16'h0010, 0, 0, 1'b1, 8'd1, 1'b1,  50, 32, 16};
    vecs[5] = '{"eps_lt",  8'd1, 16'h000F, 0, 0, 1'b1, 8'd1, 1'b0,  50, 32, 16};

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.upd_req", 32'(dp.upd_req), 32'd0);
    check("rst.upd_page", 32'(dp.upd_page), 32'd0);
    check("rst.wr_en", 32'(dp.wr_en), 32'd0);
    check("rst.iter_count", 32'(iter_count), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start+abort together in IDLE: abort wins.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // Abort coincident with ack in sweep 2; a start pulse mid-run must be ignored.
    begin_run(0, 5, 1'b0, 16'h0000, 8'd3);
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (c < 2000 && !(sweep == 1 && dp.upd_req && dp.upd_ack)) begin
      @(negedge clk); #1;
      c++;
    end
    check("abort.ack_found", 32'(c < 2000), 32'd1);
    wr_before = wcount;
    pg = int'(dp.upd_page);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort.wr_en", 32'(dp.wr_en), 32'd0);
    check("abort.upd_req", 32'(dp.upd_req), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.converged", 32'(converged), 32'd0);
    check("abort.iter_count", 32'(iter_count), 32'd1);
    check("abort.start_ignored", 32'(wr_before), 32'(32 + pg));
    repeat (4) @(posedge clk);
    #1;
    check("abort.no_write", 32'(wcount), 32'(wr_before));
    check("abort.no_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-REQ.
    begin_run(0, 5, 1'b0, 16'h0000, 8'd3);
    c = 0;
    while (c < 200 && !dp.upd_req) begin
      @(posedge clk); #1;
      c++;
    end
    check("rstreq.req_seen", 32'(dp.upd_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstreq.upd_req", 32'(dp.upd_req), 32'd0);
    check("rstreq.wr_en", 32'(dp.wr_en), 32'd0);
    check("rstreq.busy", 32'(busy), 32'd0);
    check("rstreq.done", 32'(done), 32'd0);
    check("rstreq.iter_count", 32'(iter_count), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rstreq.stay_idle", 32'(busy), 32'd0);
    check("rstreq.no_req", 32'(dp.upd_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
